param_bank_arbiter: RTL and testbench

PARAM_BANK_ARBITER -- requirements
Module: param_bank_arbiter

---
 rtl/param_bank_arbiter_pkg.sv | 25 ++
 rtl/param_bank_arbiter_if.sv | 30 +++
 rtl/param_bank_arbiter_bank_mem.sv | 25 ++
 rtl/param_bank_arbiter.sv | 138 +++++++++++++
 tb/tb_param_bank_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_bank_arbiter_pkg.sv
// Shared definitions for the shared-memory bank blocks: parameter defaults,
// address field layout helpers and the arbiter FSM/op encodings.
package param_bank_arbiter_pkg;

  localparam int DEF_N_CORES = 16;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_WADDR_W = 8;
  localparam int DEF_BANK_W  = 4;
  localparam int DEF_BANK_ID = 0;

  // Per-core address slice is {bank, word}; bank occupies the upper BANK_W bits.
  localparam int DEF_ADDR_W = DEF_BANK_W + DEF_WADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

// File: rtl/param_bank_arbiter_if.sv
// Multi-core request/response bundle between the cores (master) and one
// memory bank arbiter (slave).
interface param_bank_arbiter_if
  import param_bank_arbiter_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WADDR_W = DEF_WADDR_W,
  parameter int BANK_W  = DEF_BANK_W
);

  logic [N_CORES-1:0]                  req_read;
  logic [N_CORES-1:0]                  req_write;
  logic [N_CORES*(BANK_W+WADDR_W)-1:0] req_addr;
  logic [N_CORES*DATA_W-1:0]           req_wdata;
  logic [N_CORES*DATA_W-1:0]           rdata;
  logic [N_CORES-1:0]                  done;
  logic                                busy;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  rdata, done, busy
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output rdata, done, busy
  );

endinterface

// File: rtl/param_bank_arbiter_bank_mem.sv
// Single-port-per-direction bank storage: synchronous write, synchronous read.
// Contents are deliberately not reset.
module bank_mem
  import param_bank_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_WADDR_W
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/param_bank_arbiter.sv
// Round-robin arbiter for one memory bank shared by N_CORES cores, with
// read merging of identical pure reads into a single access.
module param_bank_arbiter
  import param_bank_arbiter_pkg::*;
#(
  parameter int N_CORES = DEF_N_CORES,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int WADDR_W = DEF_WADDR_W,
  parameter int BANK_W  = DEF_BANK_W,
  parameter int BANK_ID = DEF_BANK_ID
) (
  input logic                 clock,
  input logic                 reset,
  param_bank_arbiter_if.slave bus
);

  localparam int IDX_W  = (N_CORES > 1) ? $clog2(N_CORES) : 1;
  localparam int ADDR_W = BANK_W + WADDR_W;

  state_t                          state;
  op_t                             gnt_op;
  logic [IDX_W-1:0]                ptr;
  logic [IDX_W-1:0]                gnt_idx;
  logic [IDX_W-1:0]                sel;
  logic                            found;
  logic [WADDR_W-1:0]              gnt_word;
  logic [DATA_W-1:0]               gnt_wdata;
  logic [N_CORES-1:0]              eligible;
  logic [N_CORES-1:0]              pure_read;
  logic [N_CORES-1:0]              merge;
  logic [N_CORES-1:0]              gnt_mask;
  logic [N_CORES-1:0]              done_r;
  logic [N_CORES-1:0][WADDR_W-1:0] word;
  logic [N_CORES-1:0][DATA_W-1:0]  wdata;
  logic [DATA_W-1:0]               mem_q;
  logic                            busy_r;
  logic                            access_read;
  logic                            mem_we;
  logic                            mem_re;
  int                              cand;

  assign gnt_mask    = N_CORES'(1) << gnt_idx;
  assign access_read = (state == ST_ACCESS) && (gnt_op == OP_READ);
  // Reset in ACCESS must keep an in-flight write out of the array.
  assign mem_we      = (state == ST_ACCESS) && (gnt_op == OP_WRITE) && !reset;
  // The read is issued at the grant edge so the word is ready to land in rdata at the end of ACCESS.
  assign mem_re      = (state == ST_IDLE) && found && !reset;

  for (genvar i = 0; i < N_CORES; i++) begin : g_core
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rdata_r;

    assign addr         = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign word[i]      = addr[WADDR_W-1:0];
    assign wdata[i]     = bus.req_wdata[i*DATA_W +: DATA_W];
    assign eligible[i]  = (bus.req_read[i] | bus.req_write[i]) &&
                          (addr[ADDR_W-1:WADDR_W] == BANK_W'(BANK_ID));
    assign pure_read[i] = eligible[i] & bus.req_read[i] & ~bus.req_write[i];
    assign merge[i]     = access_read && pure_read[i] && (word[i] == gnt_word) &&
                          (gnt_idx != IDX_W'(i));
    assign bus.rdata[i*DATA_W +: DATA_W] = rdata_r;

    always_ff @(posedge clock) begin
      if (reset) rdata_r <= '0;
      else if (access_read && (gnt_mask[i] || merge[i])) rdata_r <= mem_q;
    end
  end

  // First eligible core at or above ptr, wrapping.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = 0;
    for (int k = 0; k < N_CORES; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_CORES) cand = cand - N_CORES;
      if (!found && eligible[IDX_W'(cand)]) begin
        found = 1'b1;
        sel   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      gnt_idx   <= '0;
      gnt_op    <= OP_READ;
      gnt_word  <= '0;
      gnt_wdata <= '0;
      done_r    <= '0;
      busy_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_r <= '0;
          if (found) begin
            gnt_idx   <= sel;
            gnt_op    <= bus.req_write[sel] ? OP_WRITE : OP_READ;
            gnt_word  <= word[sel];
            gnt_wdata <= wdata[sel];
            state     <= ST_ACCESS;
            busy_r    <= 1'b1;
          end
        end
        ST_ACCESS: begin
          done_r <= gnt_mask | merge;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          done_r <= '0;
          ptr    <= (gnt_idx == IDX_W'(N_CORES-1)) ? '0 : gnt_idx + 1'b1;
          state  <= ST_IDLE;
          busy_r <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.done = done_r;
  assign bus.busy = busy_r;

  bank_mem #(
    .DATA_W(DATA_W),
    .ADDR_W(WADDR_W)
  ) u_mem (
    .clock(clock),
    .we   (mem_we),
    .waddr(gnt_word),
    .wdata(gnt_wdata),
    .re   (mem_re),
    .raddr(word[sel]),
    .q    (mem_q)
  );

endmodule

// File: tb/tb_param_bank_arbiter.sv
// Bench for param_bank_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants, merges and memory.
module tb_param_bank_arbiter;
  import param_bank_arbiter_pkg::*;

  localparam int N   = 16;
  localparam int DW  = 8;
  localparam int AW  = 8;
  localparam int BW  = 4;
  localparam int ADW = AW + BW;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  param_bank_arbiter_if #(.N_CORES(N), .DATA_W(DW), .WADDR_W(AW), .BANK_W(BW)) bus0 ();
  param_bank_arbiter_if #(.N_CORES(N), .DATA_W(DW), .WADDR_W(AW), .BANK_W(BW)) bus4 ();

  param_bank_arbiter #(.N_CORES(N), .DATA_W(DW), .WADDR_W(AW), .BANK_W(BW), .BANK_ID(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.slave));
  param_bank_arbiter #(.N_CORES(N), .DATA_W(DW), .WADDR_W(AW), .BANK_W(BW), .BANK_ID(4)) dut4 (
    .clock(clock), .reset(reset), .bus(bus4.slave));

  // Model: pending request per core, bank contents, expected rdata, rr pointer.
  bit              p_rd   [N];
  bit              p_wr   [N];
  logic [BW-1:0]   p_bank [N];
  logic [AW-1:0]   p_word [N];
  logic [DW-1:0]   p_data [N];
  logic [DW-1:0]   mem_m  [256];
  bit              written[256];
  logic [DW-1:0]   rdata_m[N];
  int              ptr_m;
  int              last_g;
  int              tests = 0;
  int              fails = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit elig(int i);
    return (p_rd[i] || p_wr[i]) && (p_bank[i] == '0);
  endfunction

  function automatic logic [127:0] pack_rdata();
    logic [127:0] v = '0;
    for (int i = 0; i < N; i++) v = v | (128'(rdata_m[i]) << (i*DW));
    return v;
  endfunction

  task automatic drive();
    logic [N-1:0]     rv = '0;
    logic [N-1:0]     wv = '0;
    logic [N*ADW-1:0] av = '0;
    logic [N*DW-1:0]  dv = '0;
    for (int i = 0; i < N; i++) begin
      rv = rv | (N'(p_rd[i]) << i);
      wv = wv | (N'(p_wr[i]) << i);
      av = av | ((N*ADW)'({p_bank[i], p_word[i]}) << (i*ADW));
      dv = dv | ((N*DW)'(p_data[i]) << (i*DW));
    end
    bus0.req_read  = rv;
    bus0.req_write = wv;
    bus0.req_addr  = av;
    bus0.req_wdata = dv;
  endtask

  task automatic set_req(input int c, input bit rd, input bit wr, input logic [BW-1:0] bank,
                         input logic [AW-1:0] w, input logic [DW-1:0] d);
    p_rd[c] = rd; p_wr[c] = wr; p_bank[c] = bank; p_word[c] = w; p_data[c] = d;
  endtask

  task automatic model_reset();
    ptr_m = 0;
    for (int i = 0; i < N; i++) rdata_m[i] = '0;
  endtask

  // One arbitration decision, straight from the grant/merge rules.
  task automatic predict(output logic [N-1:0] dmask);
    int g = -1;
    logic [DW-1:0] v;
    dmask = '0;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && elig((ptr_m + k) % N)) g = (ptr_m + k) % N;
    end
    last_g = g;
    if (g < 0) return;
    dmask = dmask | (N'(1) << g);
    if (p_wr[g]) begin
      mem_m[p_word[g]]   = p_data[g];
      written[p_word[g]] = 1'b1;
    end else begin
      v = mem_m[p_word[g]];
      rdata_m[g] = v;
      for (int i = 0; i < N; i++) begin
        if (i != g && elig(i) && p_rd[i] && !p_wr[i] && p_word[i] == p_word[g]) begin
          dmask = dmask | (N'(1) << i);
          rdata_m[i] = v;
        end
      end
    end
    ptr_m = (g + 1) % N;
  endtask

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic service(input string tag, input bit keep);
    logic [N-1:0] exp_done;
    int cyc = 0;
    predict(exp_done);
    do begin
      @(negedge clock);
      cyc++;
    end while (bus0.done == '0 && cyc < 12);
    check({tag, "_done"}, 128'(bus0.done), 128'(exp_done));
    check({tag, "_lat"}, 128'(cyc), 128'd2);
    check({tag, "_busy"}, 128'(bus0.busy), 128'd1);
    check({tag, "_rdata"}, bus0.rdata, pack_rdata());
    if (!keep) begin
      for (int i = 0; i < N; i++) if (exp_done[i]) begin p_rd[i] = 0; p_wr[i] = 0; end
      drive();
    end
    @(negedge clock);
    check({tag, "_pulse"}, 128'(bus0.done), 128'd0);
    check({tag, "_idle"}, 128'(bus0.busy), 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] acc;
    int order[6] = '{0, 5, 15, 0, 5, 15};
    for (int i = 0; i < N; i++) set_req(i, 0, 0, '0, '0, '0);
    for (int i = 0; i < 256; i++) begin mem_m[i] = '0; written[i] = 1'b0; end
    model_reset();
    drive();
    bus4.req_read = '0; bus4.req_write = '0; bus4.req_addr = '0; bus4.req_wdata = '0;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_done", 128'(bus0.done), 128'd0);
    check("rst_busy", 128'(bus0.busy), 128'd0);
    check("rst_rdata", bus0.rdata, 128'd0);

    // Single write then read by core 3
    set_req(3, 0, 1, 4'h0, 8'h10, 8'hA5); drive();
    service("wr3", 0);
    set_req(3, 1, 0, 4'h0, 8'h10, 8'h00); drive();
    service("rd3", 0);
    check("rd3_const", 128'(bus0.rdata[3*DW +: DW]), 128'hA5);

    // Read+write collision: write wins, rdata untouched
    set_req(8, 1, 1, 4'h0, 8'h20, 8'h77); drive();
    service("rw8", 0);
    check("rw8_rdata_hold", 128'(bus0.rdata[8*DW +: DW]), 128'h00);
    set_req(8, 1, 0, 4'h0, 8'h20, 8'h00); drive();
    service("rd8", 0);
    check("rd8_const", 128'(bus0.rdata[8*DW +: DW]), 128'h77);

    // Read merge of cores 2, 7, 9
    set_req(2, 1, 0, 4'h0, 8'h10, 8'h00);
    set_req(7, 1, 0, 4'h0, 8'h10, 8'h00);
    set_req(9, 1, 0, 4'h0, 8'h10, 8'h00);
    drive();
    service("merge", 0);
    check("merge_r2", 128'(bus0.rdata[2*DW +: DW]), 128'hA5);
    check("merge_r7", 128'(bus0.rdata[7*DW +: DW]), 128'hA5);
    check("merge_r9", 128'(bus0.rdata[9*DW +: DW]), 128'hA5);

    // Reset during ACCESS of a write: aborted, no done, old value kept
    set_req(1, 0, 1, 4'h0, 8'h10, 8'h3C); drive();
    @(negedge clock);
    check("abort_busy_access", 128'(bus0.busy), 128'd1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_done", 128'(bus0.done), 128'd0);
    check("abort_busy", 128'(bus0.busy), 128'd0);
    check("abort_rdata_clr", bus0.rdata, 128'd0);
    set_req(1, 0, 0, 4'h0, 8'h00, 8'h00); drive();
    reset = 1'b0;
    model_reset();
    @(negedge clock);
    check("abort_no_done", 128'(bus0.done), 128'd0);
    set_req(1, 1, 0, 4'h0, 8'h10, 8'h00); drive();
    service("abort_rd", 0);
    check("abort_old", 128'(bus0.rdata[1*DW +: DW]), 128'hA5);

    // Round robin among continuously requesting cores 0, 5, 15 from reset
    reset = 1'b1;
    set_req(0, 0, 1, 4'h0, 8'h30, 8'h01);
    set_req(5, 0, 1, 4'h0, 8'h31, 8'h02);
    set_req(15, 0, 1, 4'h0, 8'h32, 8'h03);
    drive();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    for (int r = 0; r < 6; r++) begin
      service("rr", 1);
      check("rr_order", 128'(last_g), 128'(order[r]));
    end
    set_req(0, 0, 0, '0, '0, '0);
    set_req(5, 0, 0, '0, '0, '0);
    set_req(15, 0, 0, '0, '0, '0);
    drive();
    @(negedge clock);

    // Bank filter on the BANK_ID=4 instance
    bus4.req_read  = 16'h0002;
    bus4.req_write = 16'h0040;
    bus4.req_addr[1*ADW +: ADW] = 12'h305;
    bus4.req_addr[6*ADW +: ADW] = 12'h405;
    bus4.req_wdata[6*DW +: DW]  = 8'h11;
    acc = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      acc = acc | bus4.done;
      if (bus4.done[6]) bus4.req_write = 16'h0000;
    end
    check("filter_done", 128'(acc), 128'h0040);
    check("filter_busy", 128'(bus4.busy), 128'd0);
    check("filter_rdata", bus4.rdata, 128'd0);
    bus4.req_read = '0;

    // Randomized traffic against the model
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_rd[i] && !p_wr[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            logic [AW-1:0] w;
            logic [BW-1:0] b;
            int kind;
            kind = $urandom_range(0, 2);
            w    = AW'(8'h10 + $urandom_range(0, 3));
            b    = ($urandom_range(0, 4) == 0) ? BW'($urandom_range(1, 15)) : '0;
            if (kind == 0 && !written[w]) kind = 1;
            set_req(i, kind != 1, kind != 0, b, w, DW'($urandom));
          end
        end else if (p_bank[i] != '0 && $urandom_range(0, 3) == 0) begin
          set_req(i, 0, 0, '0, '0, '0);
        end
      end
      drive();
      begin
        bit any = 0;
        for (int i = 0; i < N; i++) if (elig(i)) any = 1;
        if (any) service("rand", 0);
        else @(negedge clock);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
